// File: rtl/wb_regfile_pkg.sv
// Shared widths, encodings and read-select helper for the register file.
package wb_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    localparam int REG_NUM    = 32;

    typedef logic [REG_W-1:0]      reg_word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_word_t ZERO_WORD     = '0;
    localparam logic      WRITE_ENABLE  = 1'b1;
    localparam logic      WRITE_DISABLE = 1'b0;
    localparam logic      READ_ENABLE   = 1'b1;
    localparam logic      READ_DISABLE  = 1'b0;

    // Read port value with write-first bypass; register 0 is hardwired to zero.
    function automatic reg_word_t gpr_read(
        input logic      en,
        input reg_addr_t raddr,
        input logic      wreg,
        input reg_addr_t wd,
        input reg_word_t wdata,
        input reg_word_t stored
    );
        if (en == READ_DISABLE || raddr == '0)
            return ZERO_WORD;
        else if (wreg == WRITE_ENABLE && raddr == wd)
            return wdata;
        else
            return stored;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / decode-read bundle between the pipeline and the register file.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic      wb_wreg;
    reg_addr_t wb_wd;
    reg_word_t wb_wdata;
    logic      wb_whilo;
    reg_word_t wb_hi;
    reg_word_t wb_lo;
    logic      re1;
    logic      re2;
    reg_addr_t raddr1;
    reg_addr_t raddr2;
    reg_word_t rdata1;
    reg_word_t rdata2;
    reg_word_t hi_o;
    reg_word_t lo_o;
    reg_word_t wr_cnt;

    modport master (
        output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, wr_cnt
    );

    modport slave (
        input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2, hi_o, lo_o, wr_cnt
    );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO pair: written together, with same-cycle write-through on the outputs.
module hilo_reg
    import wb_regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  reg_word_t hi_next,
    input  reg_word_t lo_next,
    output reg_word_t hi,
    output reg_word_t lo
);

    reg_word_t hi_q;
    reg_word_t lo_q;

    // Store both halves on the same edge so a partial update cannot happen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else if (wr_en == WRITE_ENABLE) begin
            hi_q <= hi_next;
            lo_q <= lo_next;
        end
    end

    // Write-through when a request is present; reset masks everything.
    always_comb begin
        hi = ZERO_WORD;
        lo = ZERO_WORD;
        if (rst) begin
            hi = (wr_en == WRITE_ENABLE) ? hi_next : hi_q;
            lo = (wr_en == WRITE_ENABLE) ? lo_next : lo_q;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 GPR file with two bypassed read ports, HI/LO pair and write counter.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    reg_word_t regs [REG_NUM];
    reg_word_t wr_cnt_q;
    reg_word_t hi_w;
    reg_word_t lo_w;
    logic      gpr_we;

    // Writes to register 0 are dropped and do not count.
    assign gpr_we = (bus.wb_wreg == WRITE_ENABLE) && (bus.wb_wd != '0);

    // GPR storage and committed-write counter; flops because of the async clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++)
                regs[i] <= ZERO_WORD;
            wr_cnt_q <= ZERO_WORD;
        end else if (gpr_we) begin
            regs[bus.wb_wd] <= bus.wb_wdata;
            wr_cnt_q        <= wr_cnt_q + 32'd1;
        end
    end

    // Combinational read ports, evaluated independently; zero while in reset.
    always_comb begin
        bus.rdata1 = ZERO_WORD;
        bus.rdata2 = ZERO_WORD;
        if (rst) begin
            bus.rdata1 = gpr_read(bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                                  bus.wb_wdata, regs[bus.raddr1]);
            bus.rdata2 = gpr_read(bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                                  bus.wb_wdata, regs[bus.raddr2]);
        end
    end

    hilo_reg u_hilo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wb_whilo),
        .hi_next (bus.wb_hi),
        .lo_next (bus.wb_lo),
        .hi      (hi_w),
        .lo      (lo_w)
    );

    assign bus.hi_o   = hi_w;
    assign bus.lo_o   = lo_w;
    assign bus.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, hand sequences, random vs model.
module tb_wb_regfile;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    wb_regfile_if bus();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_cnt;
    } vec_t;

    // Reference state: what the register file should hold after each edge.
    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        m_cnt = 32'h0;
    endtask

    // Commit whatever is on the bus at the coming edge (only outside reset).
    task automatic model_step();
        if (rst) begin
            if (bus.wb_wreg && bus.wb_wd != 5'd0) begin
                m_regs[bus.wb_wd] = bus.wb_wdata;
                m_cnt = m_cnt + 32'd1;
            end
            if (bus.wb_whilo) begin
                m_hi = bus.wb_hi;
                m_lo = bus.wb_lo;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
        if (!rst || !en || a == 5'd0) return 32'h0;
        if (bus.wb_wreg && bus.wb_wd == a) return bus.wb_wdata;
        return m_regs[a];
    endfunction

    task automatic drive(input vec_t v);
        bus.wb_wreg  = v.wreg;
        bus.wb_wd    = v.wd;
        bus.wb_wdata = v.wdata;
        bus.wb_whilo = v.whilo;
        bus.wb_hi    = v.hi;
        bus.wb_lo    = v.lo;
        bus.re1      = v.re1;
        bus.raddr1   = v.raddr1;
        bus.re2      = v.re2;
        bus.raddr2   = v.raddr2;
    endtask

    task automatic idle();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    vec_t tbl [9];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_clear();

        tbl[0] = '{1, 7, 32'hDEADBEEF, 0, 0, 0, 1, 7, 0, 7, 32'hDEADBEEF, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1};
        tbl[2] = '{1, 9, 32'hA5A5A5A5, 0, 0, 0, 1, 9, 1, 9, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1};
        tbl[3] = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 9, 0, 32'hA5A5A5A5, 0, 0, 2};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 0, 32'hDEADBEEF, 0, 0, 2};
        tbl[5] = '{0, 0, 0, 1, 32'h1, 32'h2, 0, 7, 0, 9, 0, 0, 32'h1, 32'h2, 2};
        tbl[6] = '{0, 0, 0, 0, 32'hFFFF, 32'hEEEE, 1, 9, 0, 9, 32'hA5A5A5A5, 0, 32'h1, 32'h2, 2};
        tbl[7] = '{1, 7, 32'h12345678, 1, 32'h30, 32'h40, 1, 7, 1, 9,
                   32'h12345678, 32'hA5A5A5A5, 32'h30, 32'h40, 2};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 32'h12345678, 32'h12345678, 32'h30, 32'h40, 3};

        // Reset recovery: writes presented during reset must be ignored and masked.
        rst = 1'b0;
        idle();
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd5;
        bus.wb_wdata = 32'h1234;
        bus.re1      = 1'b1;
        bus.raddr1   = 5'd5;
        bus.wb_whilo = 1'b1;
        bus.wb_hi    = 32'h77;
        bus.wb_lo    = 32'h88;
        #1;
        check("rst_rdata1_masked", bus.rdata1, 32'h0);
        check("rst_hi_masked", bus.hi_o, 32'h0);
        check("rst_lo_masked", bus.lo_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.wb_wreg  = 1'b0;
        bus.wb_whilo = 1'b0;
        #1;
        check("rec_rdata1", bus.rdata1, 32'h0);
        check("rec_wr_cnt", bus.wr_cnt, 32'h0);
        check("rec_hi", bus.hi_o, 32'h0);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d_rdata1", i), bus.rdata1, tbl[i].exp_rd1);
            check($sformatf("vec%0d_rdata2", i), bus.rdata2, tbl[i].exp_rd2);
            check($sformatf("vec%0d_hi", i), bus.hi_o, tbl[i].exp_hi);
            check($sformatf("vec%0d_lo", i), bus.lo_o, tbl[i].exp_lo);
            check($sformatf("vec%0d_wr_cnt", i), bus.wr_cnt, tbl[i].exp_cnt);
            model_step();
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.wb_wreg  = ($urandom_range(0, 3) != 0);
            bus.wb_wd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            bus.wb_wdata = $urandom;
            bus.wb_whilo = ($urandom_range(0, 2) == 0);
            bus.wb_hi    = $urandom;
            bus.wb_lo    = $urandom;
            bus.re1      = ($urandom_range(0, 4) != 0);
            bus.re2      = ($urandom_range(0, 4) != 0);
            bus.raddr1   = 5'($urandom_range(0, 7));
            bus.raddr2   = ($urandom_range(0, 1) == 0) ? bus.raddr1 : 5'($urandom_range(0, 31));
            #1;
            check("rnd_rdata1", bus.rdata1, model_read(bus.re1, bus.raddr1));
            check("rnd_rdata2", bus.rdata2, model_read(bus.re2, bus.raddr2));
            check("rnd_hi", bus.hi_o, bus.wb_whilo ? bus.wb_hi : m_hi);
            check("rnd_lo", bus.lo_o, bus.wb_whilo ? bus.wb_lo : m_lo);
            check("rnd_wr_cnt", bus.wr_cnt, m_cnt);
            model_step();
        end

        // HI/LO hold, then asynchronous reset mid-run clears immediately.
        @(negedge clk);
        idle();
        bus.wb_whilo = 1'b1;
        bus.wb_hi    = 32'h1;
        bus.wb_lo    = 32'h2;
        #1;
        model_step();
        @(negedge clk);
        bus.wb_whilo = 1'b0;
        bus.wb_hi    = 32'h9;
        bus.wb_lo    = 32'h9;
        #1;
        check("hilo_hold_hi", bus.hi_o, 32'h1);
        check("hilo_hold_lo", bus.lo_o, 32'h2);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_hi", bus.hi_o, 32'h0);
        check("midrst_lo", bus.lo_o, 32'h0);
        model_clear();
        @(negedge clk);
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd3;
        bus.wb_wdata = 32'hCAFE;
        bus.re1      = 1'b1;
        bus.raddr1   = 5'd3;
        #1;
        check("midrst_rdata1", bus.rdata1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.wb_wreg = 1'b0;
        #1;
        check("midrst_cnt", bus.wr_cnt, 32'h0);
        check("midrst_reg3", bus.rdata1, 32'h0);

        // Counter wrap: preload the counter at its maximum, then one write to r3.
        @(negedge clk);
        force dut.wr_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.wr_cnt_q;
        #1;
        check("wrap_preload", bus.wr_cnt, 32'hFFFFFFFF);
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd3;
        bus.wb_wdata = 32'h55;
        @(posedge clk);
        #1;
        check("wrap_cnt", bus.wr_cnt, 32'h0);
        @(negedge clk);
        bus.wb_wreg = 1'b0;
        bus.re1     = 1'b1;
        bus.raddr1  = 5'd3;
        #1;
        check("wrap_reg3", bus.rdata1, 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
